// File: rtl/comma_word_aligner.sv
// comma_word_aligner
//  Takes unaligned 20-bit words from the 16->20 gearbox, finds the K28.5 comma in
//  the 40-bit window {current, previous} and locks the word boundary so the comma
//  symbol lands in data_out[9:0]. Aligned words go to the 8b/10b decoder through a
//  single output register with a valid/shift handshake.
//  Optional feature macro: ALIGN_ERR_CNT_EN (adds the saturating err_cnt port).
module comma_word_aligner #(
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned UNLOCK_CNT = 3,
   parameter logic [9:0]  COMMA_P    = 10'b0101111100,
   parameter logic [9:0]  COMMA_N    = ~COMMA_P
) (
   input  logic        clk_320MHz,
   input  logic        res_n,
   input  logic        valid_in,
   input  logic [19:0] data_in,
   output logic        ready_out,
   output logic [19:0] data_out,
   output logic        valid_out,
   input  logic        shift_out,
   output logic        locked,
   output logic [4:0]  offset
`ifdef ALIGN_ERR_CNT_EN
   ,
   output logic [15:0] err_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_CNT_C   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_CNT_C = 4'(UNLOCK_CNT);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [19:0] prev_r;
   logic        primed_r;      // prev_r holds a real word
   logic [4:0]  offset_r;
   logic [4:0]  offset_nxt_s;
   logic [3:0]  cnt_r;
   logic [3:0]  cnt_nxt_s;
   logic [3:0]  bad_r;
   logic [3:0]  bad_nxt_s;
   logic [19:0] data_out_r;
   logic        valid_out_r;
   logic        locked_r;
   logic        miss_s;        // misaligned comma seen while locked
   logic        accept_s;
   logic        search_s;      // accept that carries a full window
   logic [39:0] win_s;
   logic [19:0] hit_s;
   logic        hit_any_s;
   logic [4:0]  hit_pos_s;
   logic [19:0] aligned_s;

   assign ready_out = ~valid_out_r | shift_out;
   assign accept_s  = valid_in & ready_out;
   assign search_s  = accept_s & primed_r;
   assign win_s     = {data_in, prev_r};
   assign aligned_s = 20'(win_s >> offset_r);
   assign hit_any_s = |hit_s;

   assign data_out  = data_out_r;
   assign valid_out = valid_out_r;
   assign locked    = locked_r;
   assign offset    = offset_r;

   // Comma detection at every bit offset, lowest matching offset wins.
   always_comb begin
      hit_s     = 20'd0;
      hit_pos_s = 5'd0;
      for (int p = 19; p >= 0; p--) begin
         hit_s[p]  = (win_s[p +: 10] == COMMA_P) || (win_s[p +: 10] == COMMA_N);
         hit_pos_s = hit_s[p] ? 5'(p) : hit_pos_s;
      end
   end

   // Alignment FSM next-state: moves only on an accepted word that contains a comma.
   always_comb begin
      state_nxt_s  = state_r;
      offset_nxt_s = offset_r;
      cnt_nxt_s    = cnt_r;
      bad_nxt_s    = bad_r;
      miss_s       = 1'b0;
      if (search_s && hit_any_s) begin
         case (state_r)
            ST_SEARCH: begin
               offset_nxt_s = hit_pos_s;
               cnt_nxt_s    = 4'd1;
               bad_nxt_s    = 4'd0;
               state_nxt_s  = (LOCK_CNT_C == 4'd1) ? ST_LOCKED : ST_VERIFY;
            end
            ST_VERIFY: begin
               if (hit_pos_s == offset_r) begin
                  cnt_nxt_s = cnt_r + 4'd1;
                  if ((cnt_r + 4'd1) >= LOCK_CNT_C) begin
                     state_nxt_s = ST_LOCKED;
                     bad_nxt_s   = 4'd0;
                  end else begin
                     state_nxt_s = ST_VERIFY;
                  end
               end else begin
                  offset_nxt_s = hit_pos_s;
                  cnt_nxt_s    = 4'd1;
               end
            end
            ST_LOCKED: begin
               if (hit_pos_s == offset_r) begin
                  bad_nxt_s = 4'd0;
               end else begin
                  miss_s = 1'b1;
                  if ((bad_r + 4'd1) >= UNLOCK_CNT_C) begin
                     state_nxt_s = ST_SEARCH;
                     bad_nxt_s   = 4'd0;
                  end else begin
                     bad_nxt_s = bad_r + 4'd1;
                  end
               end
            end
            default: begin
               state_nxt_s = ST_SEARCH;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // FSM state, alignment offset and lock/miss counters.
   always_ff @(posedge clk_320MHz or negedge res_n) begin
      if (!res_n) begin
         state_r  <= ST_SEARCH;
         offset_r <= 5'd0;
         cnt_r    <= 4'd0;
         bad_r    <= 4'd0;
         locked_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         offset_r <= offset_nxt_s;
         cnt_r    <= cnt_nxt_s;
         bad_r    <= bad_nxt_s;
         locked_r <= (state_nxt_s == ST_LOCKED);
      end
   end

   // Previous-word register; the first accept after reset only primes it.
   always_ff @(posedge clk_320MHz or negedge res_n) begin
      if (!res_n) begin
         prev_r   <= 20'd0;
         primed_r <= 1'b0;
      end else if (accept_s) begin
         prev_r   <= data_in;
         primed_r <= 1'b1;
      end
   end

   // Output register: loads only on accepts made while already locked, drops valid when consumed.
   always_ff @(posedge clk_320MHz or negedge res_n) begin
      if (!res_n) begin
         data_out_r  <= 20'd0;
         valid_out_r <= 1'b0;
      end else if (search_s && (state_r == ST_LOCKED)) begin
         data_out_r  <= aligned_s;
         valid_out_r <= 1'b1;
      end else if (shift_out) begin
         valid_out_r <= 1'b0;
      end
   end

`ifdef ALIGN_ERR_CNT_EN
   logic [15:0] err_cnt_r;

   assign err_cnt = err_cnt_r;

   // Saturating count of misaligned commas observed while locked.
   always_ff @(posedge clk_320MHz or negedge res_n) begin
      if (!res_n) begin
         err_cnt_r <= 16'd0;
      end else if (miss_s && (err_cnt_r != 16'hFFFF)) begin
         err_cnt_r <= err_cnt_r + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_comma_word_aligner.sv
// Self-checking bench for comma_word_aligner: table of lock scenarios, hand-built
// corner sequences and a randomized stream, all compared to a bitstream model.
`timescale 1ns/1ps
module tb_comma_word_aligner;

   localparam logic [9:0] CP = 10'b0101111100;
   localparam logic [9:0] CN = 10'b1010000011;
   localparam int LOCK_N   = 4;
   localparam int UNLOCK_N = 3;

   logic        clk_320MHz;
   logic        res_n;
   logic        valid_in;
   logic [19:0] data_in;
   logic        ready_out;
   logic [19:0] data_out;
   logic        valid_out;
   logic        shift_out;
   logic        locked;
   logic [4:0]  offset;
`ifdef ALIGN_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // model state: 0 searching, 1 verifying, 2 locked
   int          m_state;
   int          m_off;
   int          m_cnt;
   int          m_bad;
   int          m_err;
   bit          m_have;
   logic [19:0] m_prev;
   bit          m_valid;
   logic [19:0] m_data;

   logic [19:0] sw [0:63];

   comma_word_aligner dut (
      .clk_320MHz (clk_320MHz),
      .res_n      (res_n),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .ready_out  (ready_out),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .shift_out  (shift_out),
      .locked     (locked),
      .offset     (offset)
`ifdef ALIGN_ERR_CNT_EN
      ,
      .err_cnt    (err_cnt)
`endif
   );

   initial clk_320MHz = 1'b0;
   always #2 clk_320MHz = ~clk_320MHz;

   initial begin
      #1000000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_off = 0; m_cnt = 0; m_bad = 0; m_err = 0;
      m_have = 1'b0; m_prev = 20'd0; m_valid = 1'b0; m_data = 20'd0;
   endtask

   // Reference: treat the accepted words as one bitstream; the window is the last 40 bits.
   task automatic model_step(input bit acc, input logic [19:0] din, input bit sh);
      logic [39:0] win;
      logic [9:0]  sl;
      bit          any;
      int          pos;
      bit          emit;
      logic [19:0] outw;
      emit = 1'b0;
      outw = 20'd0;
      if (acc && !m_have) begin
         m_prev = din;
         m_have = 1'b1;
      end else if (acc) begin
         win    = {din, m_prev};
         m_prev = din;
         any    = 1'b0;
         pos    = 0;
         for (int p = 19; p >= 0; p--) begin
            sl = win[p +: 10];
            if (sl == CP || sl == CN) begin
               any = 1'b1;
               pos = p;
            end
         end
         emit = (m_state == 2);
         outw = win[m_off +: 20];
         if (any) begin
            if (m_state == 0) begin
               m_off = pos; m_cnt = 1; m_bad = 0;
               m_state = (LOCK_N == 1) ? 2 : 1;
            end else if (m_state == 1) begin
               if (pos == m_off) begin
                  m_cnt++;
                  if (m_cnt >= LOCK_N) begin m_state = 2; m_bad = 0; end
               end else begin
                  m_off = pos; m_cnt = 1;
               end
            end else begin
               if (pos == m_off) m_bad = 0;
               else begin
                  m_bad++;
                  if (m_err < 65535) m_err++;
                  if (m_bad >= UNLOCK_N) begin m_state = 0; m_bad = 0; end
               end
            end
         end
      end
      if (emit) begin
         m_valid = 1'b1;
         m_data  = outw;
      end else if (m_valid && sh) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic check_outputs();
      chk("valid_out", 32'(valid_out), 32'(m_valid));
      chk("data_out", 32'(data_out), 32'(m_data));
      chk("locked", 32'(locked), 32'(m_state == 2));
      chk("offset", 32'(offset), 32'(m_off));
`ifdef ALIGN_ERR_CNT_EN
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
   endtask

   // One clock: drive, check ready, clock, update model, compare outputs.
   task automatic do_cycle(input bit vin, input logic [19:0] din, input bit sh, output bit acc);
      bit exp_ready;
      valid_in  = vin;
      data_in   = din;
      shift_out = sh;
      #1;
      exp_ready = !m_valid || sh;
      chk("ready_out", 32'(ready_out), 32'(exp_ready));
      acc = vin && exp_ready;
      @(posedge clk_320MHz);
      model_step(acc, din, sh);
      #1;
      check_outputs();
   endtask

   task automatic apply_reset();
      res_n     = 1'b0;
      valid_in  = 1'b1;
      data_in   = 20'hABCDE;
      shift_out = 1'b0;
      #1;
      chk("rst_ready_out", 32'(ready_out), 32'd1);
      repeat (2) @(posedge clk_320MHz);
      #1;
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_offset", 32'(offset), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'd0);
      model_reset();
      res_n = 1'b1;
   endtask

   task automatic clear_stream();
      for (int i = 0; i < 64; i++) sw[i] = 20'd0;
   endtask

   task automatic put_comma(input int w, input int b, input bit rdp);
      logic [9:0] pat;
      int s;
      pat = rdp ? CN : CP;
      for (int i = 0; i < 10; i++) begin
         s = 20 * w + b + i;
         sw[s / 20][s % 20] = pat[i];
      end
   endtask

   // Push stream words from..to; shm=1 randomizes valid_in and shift_out.
   task automatic feed(input int from, input int to, input int shm);
      int idx;
      int guard;
      bit acc;
      bit vin;
      bit sh;
      idx = from;
      guard = 0;
      while (idx <= to && guard < 2000) begin
         vin = (shm == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         sh  = (shm == 1) ? ($urandom_range(0, 9) < 7) : 1'b1;
         do_cycle(vin, sw[idx], sh, acc);
         if (acc) idx++;
         guard++;
      end
      chk("feed_done", 32'(idx > to), 32'd1);
   endtask

   function automatic logic [19:0] gen_word(input int idx, input int b);
      logic [19:0] w;
      logic [9:0]  pat;
      w   = ($urandom_range(0, 1) == 1) ? 20'($urandom) : 20'd0;
      pat = ($urandom_range(0, 1) == 1) ? CN : CP;
      if (idx % 3 == 0) w[b +: 10] = pat;
      return w;
   endfunction

   typedef struct {
      int off;
      int period;
      bit rdp;
      int ncom;
      bit exp_lock;
      int exp_off;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [19:0] hold;
      bit acc;
      bit vin;
      bit sh;
      int roff;
      int rw;
      logic [19:0] cur;

      res_n = 1'b0; valid_in = 1'b0; data_in = 20'd0; shift_out = 1'b0;
      model_reset();

      tbl[0] = '{off: 7,  period: 4, rdp: 1'b0, ncom: 4, exp_lock: 1'b1, exp_off: 7};
      tbl[1] = '{off: 7,  period: 4, rdp: 1'b0, ncom: 3, exp_lock: 1'b0, exp_off: 7};
      tbl[2] = '{off: 0,  period: 1, rdp: 1'b1, ncom: 4, exp_lock: 1'b1, exp_off: 0};
      tbl[3] = '{off: 19, period: 2, rdp: 1'b0, ncom: 5, exp_lock: 1'b1, exp_off: 19};
      tbl[4] = '{off: 12, period: 3, rdp: 1'b1, ncom: 4, exp_lock: 1'b1, exp_off: 12};
      tbl[5] = '{off: 5,  period: 1, rdp: 1'b0, ncom: 1, exp_lock: 1'b0, exp_off: 5};
      tbl[6] = '{off: 3,  period: 2, rdp: 1'b1, ncom: 4, exp_lock: 1'b1, exp_off: 3};

      for (int t = 0; t < 7; t++) begin
         apply_reset();
         clear_stream();
         for (int c = 0; c < tbl[t].ncom; c++) put_comma(c * tbl[t].period, tbl[t].off, tbl[t].rdp);
         feed(0, (tbl[t].ncom - 1) * tbl[t].period + 1, 0);
         chk("tbl_locked", 32'(locked), 32'(tbl[t].exp_lock));
         chk("tbl_offset", 32'(offset), 32'(tbl[t].exp_off));
      end

      // Comma at offset 7 every 4th word; comma symbol lands in data_out[9:0].
      apply_reset();
      clear_stream();
      for (int c = 0; c < 6; c++) put_comma(4 * c, 7, 1'b0);
      feed(0, 13, 0);
      chk("t2_locked", 32'(locked), 32'd1);
      feed(14, 17, 0);
      chk("t2_comma_in_low", 32'(data_out[9:0]), 32'(CP));

      // Lose lock after 3 misaligned commas, relock elsewhere, survive 2 misses.
      apply_reset();
      clear_stream();
      for (int c = 0; c < 4; c++) put_comma(2 * c, 7, 1'b0);
      for (int c = 0; c < 3; c++) put_comma(8 + 2 * c, 12, 1'b0);
      for (int c = 0; c < 4; c++) put_comma(14 + 2 * c, 12, 1'b0);
      put_comma(22, 5, 1'b0);
      put_comma(24, 5, 1'b0);
      put_comma(26, 12, 1'b0);
      put_comma(28, 5, 1'b0);
      put_comma(30, 5, 1'b0);
      feed(0, 7, 0);
      chk("t3_lock7", 32'(locked), 32'd1);
      chk("t3_off7", 32'(offset), 32'd7);
      feed(8, 11, 0);
      chk("t3_two_miss_locked", 32'(locked), 32'd1);
      feed(12, 13, 0);
      chk("t3_unlock", 32'(locked), 32'd0);
      feed(14, 21, 0);
      chk("t3_relock", 32'(locked), 32'd1);
      chk("t3_off12", 32'(offset), 32'd12);
      feed(22, 31, 0);
      chk("t3_stay_locked", 32'(locked), 32'd1);
      chk("t3_stay_off", 32'(offset), 32'd12);

      // Backpressure on a ramp: outputs frozen, nothing lost or repeated.
      apply_reset();
      clear_stream();
      for (int w = 8; w < 20; w++) sw[w] = 20'h04321 + 20'(w);
      for (int c = 0; c < 10; c++) put_comma(2 * c, 7, 1'b0);
      feed(0, 9, 0);
      hold = data_out;
      chk("t4_valid_before", 32'(valid_out), 32'd1);
      for (int k = 0; k < 5; k++) begin
         do_cycle(1'b1, sw[10], 1'b0, acc);
         chk("t4_stall_data", 32'(data_out), 32'(hold));
         chk("t4_stall_valid", 32'(valid_out), 32'd1);
         chk("t4_stall_ready", 32'(ready_out), 32'd0);
      end
      feed(10, 19, 0);

      // Asynchronous reset while an output word is pending.
      chk("t6_pre_valid", 32'(valid_out), 32'd1);
      #1;
      res_n = 1'b0;
      #0.5;
      chk("t6_async_valid", 32'(valid_out), 32'd0);
      chk("t6_async_locked", 32'(locked), 32'd0);
      chk("t6_async_offset", 32'(offset), 32'd0);
      @(posedge clk_320MHz);
      #1;
      res_n = 1'b1;
      model_reset();

      // Misaligned commas interleaved with aligned ones while locked.
      apply_reset();
      clear_stream();
      for (int c = 0; c < 4; c++) put_comma(2 * c, 7, 1'b0);
      for (int c = 0; c < 5; c++) begin
         put_comma(8 + 4 * c, 12, 1'b0);
         put_comma(10 + 4 * c, 7, 1'b0);
      end
      feed(0, 27, 0);
      chk("t6_locked", 32'(locked), 32'd1);
`ifdef ALIGN_ERR_CNT_EN
      chk("t6_err_cnt5", 32'(err_cnt), 32'd5);
      #1;
      res_n = 1'b0;
      #0.5;
      chk("t6_err_cleared", 32'(err_cnt), 32'd0);
      @(posedge clk_320MHz);
      #1;
      res_n = 1'b1;
      model_reset();
`endif

      // Randomized stream with random valid_in/shift_out.
      apply_reset();
      roff = 9;
      rw   = 0;
      cur  = gen_word(rw, roff);
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (cyc % 300 == 299) roff = int'($urandom_range(0, 10));
         vin = ($urandom_range(0, 3) != 0);
         sh  = ($urandom_range(0, 9) < 7);
         do_cycle(vin, cur, sh, acc);
         if (acc) begin
            rw++;
            cur = gen_word(rw, roff);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
